ram_word_loader: RTL and testbench
==================================

# ram_word_loader

Host-side loader/unloader that sits directly upstream of the `tiny` core's operand RAM port (`sel`/`addr`/`w`/`data`/`out`). It assembles 1188-bit GF(3^593) RAM words from a 32-bit valid/ready beat stream and writes them into the core's RAM. On a read command it fetches a RAM word and streams it back as 32-bit beats. It owns the RAM port only while the core is idle.

## Interface
Parameters:
- `WIDTH_D0`, 1187: MSB index of a RAM word (word width is 1188).
- `BEAT`, 32: host beat width.
- `ADDR_W`, 6: RAM address width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `core_idle`  in  1: core not computing; the port may be taken.
- `cmd_valid`/`cmd_ready`  in/out  1: command handshake.
- `cmd_write`  in  1: 1 = load word, 0 = read word.
- `cmd_addr`  in  6: RAM address.
- `in_valid`/`in_ready`  in/out  1: write-data beat handshake.
- `in_data`  in  32: write beat.
- `out_valid`/`out_ready`  out/in  1: read-data beat handshake.
- `out_data`  out  32: read beat.
- `ram_sel`  out  1: drives core `sel`.
- `ram_addr`  out  6: drives core `addr`.
- `ram_w`  out  1: drives core `w`.
- `ram_data`  out  1188: drives core `data`.
- `ram_out`  in  1188: core `out`.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- NBEATS = 38 (ceil(1188/32)). Beats are transferred LS-first: beat k carries word bits [32k+31:32k].
- Beat 37 (the last beat) carries only bits [1187:1184] in `in_data[3:0]`. On write, `in_data[31:4]` of beat 37 is ignored. On read, `out_data[31:4]` of beat 37 is 0.
- States are IDLE, COLLECT, WRITE, RD_ADDR, RD_WAIT, EMIT.
  - IDLE: `cmd_ready = core_idle`. On a command handshake, latch `cmd_addr` and clear the beat counter. If `cmd_write`=1, go to COLLECT; otherwise go to RD_ADDR.
  - COLLECT: `in_ready`=1. Each accepted beat is shifted into the word register and the counter increments. Acceptance of beat 37 moves to WRITE.
  - WRITE: exactly one cycle with `ram_sel`=1, `ram_w`=1, the latched `ram_addr`, and the assembled `ram_data`. Then return to IDLE.
  - RD_ADDR: one cycle with `ram_sel`=1, `ram_w`=0, the latched address.
  - RD_WAIT: the same drive as RD_ADDR for one more cycle. On the edge that ends RD_WAIT, capture `ram_out` into the word register.
  - EMIT: `out_valid`=1 and `out_data` is the current low 32 bits. On each handshake, shift right by 32 and increment the counter. The handshake of beat 37 returns to IDLE.
- `ram_sel`=0 in IDLE, COLLECT and EMIT, so the core owns its RAM whenever the loader is not actively accessing it.
- `ram_w` is never high outside WRITE.
- A command is never accepted while `core_idle`=0. A command already in progress is not aborted if `core_idle` falls.

## Timing
- Reset values: state IDLE, `cmd_ready`=`core_idle` (combinational from state), `in_ready`=0, `out_valid`=0, `out_data`=0, `ram_sel`=0, `ram_w`=0, `ram_addr`=0, `ram_data`=0, `busy`=0.
- Reset asserted mid-operation aborts immediately. The partial word is discarded, no `ram_w` pulse is issued, and `out_valid` drops.
- Write latency: `ram_w` goes high in the cycle after beat 37 is accepted.
- Read latency: the first `out_valid` occurs 3 cycles after the command handshake (RD_ADDR, RD_WAIT, then EMIT).
- While `out_valid`=1 and `out_ready`=0, `out_data` holds stable.
- `in_valid` low stalls COLLECT indefinitely, with no timeout.
- `cmd_ready` is low in every state except IDLE. Back-to-back commands have a minimum 1-cycle IDLE gap.
- `ram_data` holds its last value outside WRITE. The core ignores it when `w`=0.

## Structure
- Shared package `tiny_pkg` holds `WIDTH_D0`, `BEAT`, `NBEATS`, `ADDR_W` and the state enum. The pairing core also uses `WIDTH_D0`.
- One sub-module, `ram_word_shift`, is a 1188-bit register with three operations:
  - shift-in of 32 bits at the MS end, used in COLLECT;
  - parallel load, used at the end of RD_WAIT;
  - shift-right by 32, used in EMIT.
- The top contains the FSM and the 6-bit beat counter.

## Test plan
- Write to address 0: zero-extend the 198-bit value 0x115a25886512165251569195908560596a6695612620504191 to 1188 bits and send 38 beats. Expect one `ram_w` pulse with `ram_addr`=0 and `ram_data` equal to that value, then `cmd_ready`=1 the next cycle.
- Read from address 3, with a behavioural RAM model holding 0x1559546442405a181195655549614540592955a15a26984015. Expect 38 beats: beat 0 = 0x5a26984015 & 0xFFFFFFFF = 0x26984015; beats 7..37 = 0. `ram_w` stays 0 throughout.
- Backpressure: read with `out_ready` toggling every other cycle. Each beat holds stable until accepted, and exactly 38 handshakes complete.
- Last-beat masking: write with every beat = 0xFFFFFFFF. Expect `ram_data` all ones in [1187:0]; bits above 1187 do not exist.
- Reset after 10 accepted write beats: no `ram_w` pulse, `busy`=0, and a following 38-beat write completes correctly.
- `core_idle`=0 with `cmd_valid`=1: `cmd_ready`=0 and `ram_sel`=0 for 20 cycles. Raising `core_idle` accepts the command on the next edge.

Source files
------------

// File: rtl/tiny_pkg.sv
// Shared constants for the tiny pairing core and its host-side RAM word loader.
// The state enum is the loader FSM encoding.
package tiny_pkg;
  localparam int WIDTH_D0  = 1187;
  localparam int BEAT      = 32;
  localparam int NBEATS    = (WIDTH_D0 + BEAT) / BEAT;
  localparam int ADDR_W    = 6;
  localparam int LAST_BITS = WIDTH_D0 + 1 - (NBEATS - 1) * BEAT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_EMIT
  } state_e;
endpackage

// File: rtl/ram_word_shift.sv
// Word register for the loader: beat shift-in at the MS end, parallel load,
// and shift-right by one beat for streaming out.
module ram_word_shift #(
  parameter int DW   = 1188,
  parameter int BW   = 32,
  parameter int LAST = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          shin_en_i,
  input  logic          shin_last_i,
  input  logic [BW-1:0] shin_data_i,
  input  logic          load_en_i,
  input  logic [DW-1:0] load_data_i,
  input  logic          shr_en_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] word_q, word_d;

  // The final beat only carries LAST bits, so it shifts by LAST instead of a
  // full beat; this leaves beat 0 exactly at [BW-1:0] when assembly completes.
  always_comb begin
    word_d = word_q;
    if (load_en_i)
      word_d = load_data_i;
    else if (shin_en_i)
      word_d = shin_last_i ? {shin_data_i[LAST-1:0], word_q[DW-1:LAST]}
                           : {shin_data_i, word_q[DW-1:BW]};
    else if (shr_en_i)
      word_d = word_q >> BW;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) word_q <= '0;
    else       word_q <= word_d;

  assign q_o = word_q;
endmodule

// File: rtl/ram_word_loader.sv
// Loads/unloads 1188-bit operand RAM words of the tiny core over 32-bit
// valid/ready beat streams; takes the RAM port only while the core is idle.
module ram_word_loader #(
  parameter int WIDTH_D0 = tiny_pkg::WIDTH_D0,
  parameter int BEAT     = tiny_pkg::BEAT,
  parameter int ADDR_W   = tiny_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_idle,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT-1:0]   out_data,
  output logic              ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w,
  output logic [WIDTH_D0:0] ram_data,
  input  logic [WIDTH_D0:0] ram_out,
  output logic              busy
);
  localparam int W     = WIDTH_D0 + 1;
  localparam int NB    = (WIDTH_D0 + BEAT) / BEAT;
  localparam int LASTB = W - (NB - 1) * BEAT;
  localparam int CNT_W = $clog2(NB);

  tiny_pkg::state_e  state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [W-1:0]      ram_data_q, ram_data_d;
  logic [W-1:0]      word;
  logic              shin_en, load_en, shr_en, last_beat;

  assign last_beat = (cnt_q == CNT_W'(NB - 1));

  ram_word_shift #(.DW(W), .BW(BEAT), .LAST(LASTB)) u_word (
    .clk_i       (clk),
    .rst_i       (reset),
    .shin_en_i   (shin_en),
    .shin_last_i (last_beat),
    .shin_data_i (in_data),
    .load_en_i   (load_en),
    .load_data_i (ram_out),
    .shr_en_i    (shr_en),
    .q_o         (word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    ram_data_d = ram_data_q;
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    ram_sel    = 1'b0;
    ram_w      = 1'b0;
    shin_en    = 1'b0;
    load_en    = 1'b0;
    shr_en     = 1'b0;
    unique case (state_q)
      tiny_pkg::S_IDLE: begin
        cmd_ready = core_idle;
        if (cmd_valid && core_idle) begin
          addr_d  = cmd_addr;
          cnt_d   = '0;
          state_d = cmd_write ? tiny_pkg::S_COLLECT : tiny_pkg::S_RD_ADDR;
        end
      end
      tiny_pkg::S_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shin_en = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_beat) state_d = tiny_pkg::S_WRITE;
        end
      end
      tiny_pkg::S_WRITE: begin
        ram_sel    = 1'b1;
        ram_w      = 1'b1;
        ram_data_d = word;
        state_d    = tiny_pkg::S_IDLE;
      end
      tiny_pkg::S_RD_ADDR: begin
        ram_sel = 1'b1;
        state_d = tiny_pkg::S_RD_WAIT;
      end
      tiny_pkg::S_RD_WAIT: begin
        ram_sel = 1'b1;
        load_en = 1'b1;
        state_d = tiny_pkg::S_EMIT;
      end
      tiny_pkg::S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          shr_en = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_beat) state_d = tiny_pkg::S_IDLE;
        end
      end
      default: state_d = tiny_pkg::S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= tiny_pkg::S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ram_data_q <= ram_data_d;
    end

  // The word register keeps moving after a write; the port shows the last
  // written word instead so ram_data stays put while w is low.
  assign ram_data = (state_q == tiny_pkg::S_WRITE) ? word : ram_data_q;
  assign ram_addr = addr_q;
  assign out_data = out_valid ? word[BEAT-1:0] : '0;
  assign busy     = (state_q != tiny_pkg::S_IDLE);
endmodule

// File: tb/tb_ram_word_loader.sv
// Scoreboard bench for ram_word_loader: random and directed load/unload traffic
// against a word-level RAM reference model.
module tb_ram_word_loader;
  localparam int W  = 1188;
  localparam int NB = 38;

  logic          clk = 1'b0, reset = 1'b1, core_idle = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [5:0]    cmd_addr = '0;
  logic [31:0]   in_data = '0;
  logic          cmd_ready, in_ready, out_valid, ram_sel, ram_w, busy;
  logic [5:0]    ram_addr;
  logic [31:0]   out_data;
  logic [W-1:0]  ram_data;
  logic [W-1:0]  ram_out = '0;

  always #5 clk = ~clk;

  ram_word_loader dut (
    .clk(clk), .reset(reset), .core_idle(core_idle),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_w(ram_w), .ram_data(ram_data),
    .ram_out(ram_out), .busy(busy)
  );

  // Core RAM stand-in (registered read) and the bench's own view of contents
  logic [W-1:0] mem     [64];
  logic [W-1:0] ref_mem [64];
  always @(posedge clk) begin
    if (ram_sel && ram_w) mem[ram_addr] <= ram_data;
    ram_out <= mem[ram_addr];
  end

  typedef struct { logic [5:0] addr; logic [W-1:0] data; } wr_t;
  wr_t          wq[$];
  logic [31:0]  rq[$];
  logic [31:0]  cap[$];
  int           total = 0, bad = 0;
  int           rdy_mode = 0;
  logic         drop_idle = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got low64 %h expected low64 %h (%0d bits differ)",
               nm, act[63:0], exp[63:0], $countones(act ^ exp));
    end
  endtask

  task automatic fail_now(input string nm, input string what);
    total++; bad++;
    $display("FAIL %s: %s", nm, what);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a beat
  wr_t          mon_e;
  logic         stall_prev = 1'b0;
  logic [31:0]  prev_data = '0;
  initial forever begin
    @(negedge clk);
    if (reset) stall_prev = 1'b0;
    else begin
      if (ram_w) begin
        chk("w_implies_sel", ram_sel, 1);
        if (wq.size() == 0) fail_now("unexpected_ram_w", $sformatf("got pulse at addr %0d expected none", ram_addr));
        else begin
          mon_e = wq.pop_front();
          chk("wr_addr", ram_addr, mon_e.addr);
          chkw("wr_data", ram_data, mon_e.data);
        end
      end
      if (out_valid) begin
        if (stall_prev) chk("out_hold", out_data, prev_data);
        if (out_ready) begin
          cap.push_back(out_data);
          if (rq.size() == 0) fail_now("unexpected_beat", $sformatf("got %0h expected none", out_data));
          else chk("rd_beat", out_data, rq.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_cmd(input logic wr, input logic [5:0] a, output logic ok);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    ok = cmd_ready;
    if (!ok) fail_now("cmd_timeout", "got no cmd_ready expected it within 200 cycles");
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [NB*32-1:0] beats,
                          input int gaps, input int abort_after);
    logic ok; int n; wr_t e;
    if (abort_after < 0) begin
      e.addr = a; e.data = beats[W-1:0];
      wq.push_back(e);
      ref_mem[a] = beats[W-1:0];
    end
    issue_cmd(1'b1, a, ok);
    if (!ok) return;
    if (drop_idle) core_idle = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (k == abort_after) begin
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_ram_w", ram_w, 0);
        chk("abort_in_ready", in_ready, 0);
        reset = 1'b0;
        tick();
        return;
      end
      while (gaps > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_data = $urandom; tick();
      end
      in_valid = 1'b1; in_data = beats[k*32 +: 32];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) begin fail_now("in_timeout", "got no in_ready expected it"); in_valid = 1'b0; return; end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("wr_latency", ram_w, 1);
    core_idle = 1'b1;
    @(negedge clk);
    chk("post_wr_ready", cmd_ready, 1);
    chk("post_wr_busy", busy, 0);
    tick();
  endtask

  task automatic wait_read_done();
    int n = 0;
    while (rq.size() > 0 && n < 600) begin @(negedge clk); n++; end
    if (rq.size() > 0) begin
      fail_now("rd_timeout", $sformatf("got %0d beats pending expected 0", rq.size()));
      rq.delete();
    end
    n = 0;
    while (busy && n < 5) begin @(negedge clk); n++; end
    chk("rd_done_idle", busy, 0);
    chk("rd_count", cap.size(), NB);
    tick();
  endtask

  task automatic do_read(input logic [5:0] a, input int mode);
    logic ok; int n;
    rdy_mode = mode;
    for (int k = 0; k < NB; k++) rq.push_back(32'(ref_mem[a] >> (32 * k)));
    cap.delete();
    issue_cmd(1'b0, a, ok);
    if (!ok) begin rq.delete(); return; end
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 10);
    chk("rd_latency", n, 3);
    wait_read_done();
  endtask

  function automatic logic [NB*32-1:0] rand_beats();
    logic [NB*32-1:0] v;
    for (int k = 0; k < NB; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected one before time limit");
    $fatal(1, "watchdog");
  end

  logic [NB*32-1:0] bv;
  logic [W-1:0]     wv;
  initial begin
    for (int a = 0; a < 64; a++) begin
      bv = rand_beats();
      mem[a] = bv[W-1:0];
      ref_mem[a] = bv[W-1:0];
    end
    mem[3]     = 1188'h1559546442405a181195655549614540592955a15a26984015;
    ref_mem[3] = mem[3];

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ram_sel", ram_sel, 0);
    chk("rst_ram_w", ram_w, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chkw("rst_ram_data", ram_data, '0);
    chk("rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();

    wv = 1188'h115a25886512165251569195908560596a6695612620504191;
    bv = '0; bv[W-1:0] = wv;
    do_write(6'd0, bv, 0, -1);

    do_read(6'd3, 0);
    if (cap.size() == NB) begin
      chk("rd3_beat0", cap[0], 32'h26984015);
      for (int k = 7; k < NB; k++) chk($sformatf("rd3_beat%0d", k), cap[k], 0);
    end

    do_read(6'd0, 1);

    bv = '1;
    do_write(6'd5, bv, 0, -1);
    do_read(6'd5, 2);

    do_write(6'd7, rand_beats(), 0, 10);
    chk("post_abort_busy", busy, 0);
    do_write(6'd7, rand_beats(), 1, -1);
    do_read(6'd7, 0);

    core_idle = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("noidle_cmd_ready", cmd_ready, 0);
      chk("noidle_ram_sel", ram_sel, 0);
    end
    tick();
    core_idle = 1'b1;
    rdy_mode = 0;
    for (int k = 0; k < NB; k++) rq.push_back(32'(ref_mem[3] >> (32 * k)));
    cap.delete();
    @(negedge clk);
    chk("idle_rise_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("idle_accept_busy", busy, 1);
    wait_read_done();

    for (int i = 0; i < 16; i++) begin
      drop_idle = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) do_write(6'($urandom_range(0, 63)), rand_beats(), 1, -1);
      else                           do_read(6'($urandom_range(0, 63)), $urandom_range(0, 2));
      drop_idle = 1'b0;
    end

    repeat (3) tick();
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
